rr_grant_arbiter: RTL and testbench

//  Registered round-robin arbiter: shares one resource among N requesters (N=2 drives the

---
 rtl/arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 26 ++
 rtl/rr_grant_arbiter.sv | 97 +++++++++
 tb/tb_rr_grant_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and one-hot helper for the round-robin arbiter
package arb_pkg;

    typedef enum logic {IDLE, OWNED} arb_state_t;

    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request bit searching from start upward, wrapping N-1 -> 0
module rr_pick #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scan farthest-first so the nearest candidate is the last one written.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(start) + k) % N;
            if (req[IW'(j)]) begin
                found = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered round-robin arbiter with optional hold limit
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N = 2,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HMAX = HW'((MAX_HOLD < 1) ? 0 : MAX_HOLD - 1);

    arb_state_t state, state_n;
    logic [N-1:0] grant_n;
    logic [IW-1:0] id_n, last_owner, last_n, idle_idx, own_idx;
    logic [HW-1:0] hold_cnt, hold_n;
    logic busy_n, idle_found, own_found;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N)) u_idle_pick (
        .req(request),
        .start(inc(last_owner)),
        .found(idle_found),
        .idx(idle_idx)
    );

    // The owner is masked out, so own_found means "someone else is waiting".
    rr_pick #(.N(N)) u_own_pick (
        .req(request & ~N'(onehot(int'(grant_id)))),
        .start(inc(grant_id)),
        .found(own_found),
        .idx(own_idx)
    );

    always_comb begin
        state_n = state;
        grant_n = grant;
        id_n = grant_id;
        busy_n = busy;
        hold_n = hold_cnt;
        last_n = last_owner;
        if (state == IDLE) begin
            if (idle_found) begin
                state_n = OWNED;
                grant_n = N'(onehot(int'(idle_idx)));
                id_n = idle_idx;
                busy_n = 1'b1;
                hold_n = '0;
                last_n = idle_idx;
            end else begin
                grant_n = '0;
                busy_n = 1'b0;
            end
        end else if ((!request[grant_id] || (MAX_HOLD != 0 && hold_cnt == HMAX)) && own_found) begin
            grant_n = N'(onehot(int'(own_idx)));
            id_n = own_idx;
            hold_n = '0;
            last_n = own_idx;
        end else if (!request[grant_id]) begin
            state_n = IDLE;
            grant_n = '0;
            busy_n = 1'b0;
            hold_n = '0;
        end else begin
            hold_n = (hold_cnt == HMAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            grant_id <= '0;
            busy <= 1'b0;
            hold_cnt <= '0;
            last_owner <= IW'(N - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            grant_id <= id_n;
            busy <= busy_n;
            hold_cnt <= hold_n;
            last_owner <= last_n;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: directed and randomized checks of three arbiter configurations
module tb_rr_grant_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req0 = '0, req1 = '0, g0, g1;
    logic [0:0] id0, id1;
    logic b0, b1;
    logic [2:0] req2 = '0, g2;
    logic [1:0] id2;
    logic b2;

    int errors = 0;
    int checks = 0;

    rr_grant_arbiter #(.N(2), .MAX_HOLD(0)) d0 (.clk(clk), .rst(rst), .request(req0), .grant(g0), .grant_id(id0), .busy(b0));
    rr_grant_arbiter #(.N(2), .MAX_HOLD(4)) d1 (.clk(clk), .rst(rst), .request(req1), .grant(g1), .grant_id(id1), .busy(b1));
    rr_grant_arbiter #(.N(3), .MAX_HOLD(2)) d2 (.clk(clk), .rst(rst), .request(req2), .grant(g2), .grant_id(id2), .busy(b2));

    // Reference: owner, last issued owner, and how many cycles the owner has held so far.
    typedef struct {
        int n;
        int mh;
        bit busy;
        int owner;
        int last;
        int run;
    } mdl_t;
    mdl_t m[3];

    function automatic int pick(int req, int start, int n);
        for (int k = 0; k < n; k++) begin
            int j = (start + k) % n;
            if (((req >> j) & 1) != 0) return j;
        end
        return 0;
    endfunction

    function automatic void mreset(int i);
        m[i].busy = 0;
        m[i].owner = 0;
        m[i].last = m[i].n - 1;
        m[i].run = 0;
    endfunction

    function automatic void mstep(int i, int req);
        int others;
        bit own;
        if (!m[i].busy) begin
            if (req != 0) begin
                m[i].owner = pick(req, (m[i].last + 1) % m[i].n, m[i].n);
                m[i].last = m[i].owner;
                m[i].busy = 1;
                m[i].run = 1;
            end
        end else begin
            own = ((req >> m[i].owner) & 1) != 0;
            others = req & ~(1 << m[i].owner);
            if ((!own || (m[i].mh != 0 && m[i].run >= m[i].mh)) && others != 0) begin
                m[i].owner = pick(others, (m[i].owner + 1) % m[i].n, m[i].n);
                m[i].last = m[i].owner;
                m[i].run = 1;
            end else if (!own) begin
                m[i].busy = 0;
            end else begin
                m[i].run++;
            end
        end
    endfunction

    function automatic int exp_g(int i);
        return m[i].busy ? (1 << m[i].owner) : 0;
    endfunction

    task automatic tick(input logic [1:0] r0, input logic [1:0] r1, input logic [2:0] r2);
        req0 = r0;
        req1 = r1;
        req2 = r2;
        @(posedge clk);
        mstep(0, int'(r0));
        mstep(1, int'(r1));
        mstep(2, int'(r2));
        #1;
    endtask

    task automatic do_reset();
        req0 = '0;
        req1 = '0;
        req2 = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) mreset(i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (g0 !== 2'b00 || b0 !== 1'b0 || id0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_d0: got grant=%b busy=%b id=%b expected 00/0/0", g0, b0, id0);
        end
        checks++;
        if (g2 !== 3'b000 || b2 !== 1'b0 || id2 !== 2'b00) begin
            errors++;
            $display("FAIL reset_d2: got grant=%b busy=%b id=%b expected 000/0/00", g2, b2, id2);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) mreset(i);
        for (int c = 0; c < 3; c++) tick(2'b11, 2'b11, 3'b111);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (g0 !== 2'b00 || b0 !== 1'b0 || g1 !== 2'b00 || g2 !== 3'b000 || b2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got g0=%b b0=%b g1=%b g2=%b b2=%b expected all zero", g0, b0, g1, g2, b2);
        end
        for (int i = 0; i < 3; i++) mreset(i);
        @(negedge clk);
        rst = 1'b0;
        tick(2'b11, 2'b00, 3'b000);
        checks++;
        if (g0 !== 2'b01 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_grant: got grant=%b busy=%b expected 01/1", g0, b0);
        end
    endtask

    task automatic test_request_release();
        do_reset();
        tick(2'b10, 2'b00, 3'b000);
        checks++;
        if (g0 !== 2'b10 || id0 !== 1'b1 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got grant=%b id=%b busy=%b expected 10/1/1", g0, id0, b0);
        end
        tick(2'b00, 2'b00, 3'b000);
        checks++;
        if (g0 !== 2'b00 || b0 !== 1'b0) begin
            errors++;
            $display("FAIL release: got grant=%b busy=%b expected 00/0", g0, b0);
        end
    endtask

    task automatic test_switch();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick(2'b11, 2'b00, 3'b000);
            checks++;
            if (g0 !== 2'b01) begin
                errors++;
                $display("FAIL switch_hold c=%0d: got %b expected 01", c, g0);
            end
        end
        tick(2'b10, 2'b00, 3'b000);
        checks++;
        if (g0 !== 2'b10 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL switch_no_gap: got grant=%b busy=%b expected 10/1", g0, b0);
        end
    endtask

    task automatic test_hold_limit();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            logic [1:0] e;
            e = ((c / 4) % 2 != 0) ? 2'b10 : 2'b01;
            tick(2'b00, 2'b11, 3'b000);
            checks++;
            if (g1 !== e) begin
                errors++;
                $display("FAIL hold_limit c=%0d: got %b expected %b", c, g1, e);
            end
        end
    endtask

    task automatic test_no_contention();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 2'b01, 3'b000);
            checks++;
            if (g1 !== 2'b01) begin
                errors++;
                $display("FAIL no_contention c=%0d: got %b expected 01", c, g1);
            end
        end
    endtask

    task automatic test_three();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            logic [2:0] e;
            logic [1:0] ei;
            ei = 2'((c / 2) % 3);
            e = 3'b001 << ei;
            tick(2'b00, 2'b00, 3'b111);
            checks++;
            if (g2 !== e || id2 !== ei) begin
                errors++;
                $display("FAIL three_way c=%0d: got grant=%b id=%0d expected %b/%0d", c, g2, id2, e, ei);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] r0, r1;
        logic [2:0] r2;
        r0 = '0;
        r1 = '0;
        r2 = '0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (b < 2 && $urandom_range(0, 3) == 0) r0[b] = ~r0[b];
                if (b < 2 && $urandom_range(0, 3) == 0) r1[b] = ~r1[b];
                if ($urandom_range(0, 3) == 0) r2[b] = ~r2[b];
            end
            tick(r0, r1, r2);
            checks++;
            if (g0 !== 2'(exp_g(0)) || b0 !== m[0].busy || (m[0].busy && id0 !== 1'(m[0].owner))) begin
                errors++;
                $display("FAIL rand_d0 c=%0d: got grant=%b id=%0d busy=%b expected %b/%0d/%b", c, g0, id0, b0, 2'(exp_g(0)), m[0].owner, m[0].busy);
            end
            checks++;
            if (g1 !== 2'(exp_g(1)) || b1 !== m[1].busy || (m[1].busy && id1 !== 1'(m[1].owner))) begin
                errors++;
                $display("FAIL rand_d1 c=%0d: got grant=%b id=%0d busy=%b expected %b/%0d/%b", c, g1, id1, b1, 2'(exp_g(1)), m[1].owner, m[1].busy);
            end
            checks++;
            if (g2 !== 3'(exp_g(2)) || b2 !== m[2].busy || (m[2].busy && id2 !== 2'(m[2].owner))) begin
                errors++;
                $display("FAIL rand_d2 c=%0d: got grant=%b id=%0d busy=%b expected %b/%0d/%b", c, g2, id2, b2, 3'(exp_g(2)), m[2].owner, m[2].busy);
            end
            checks++;
            if (!$onehot0(g0) || !$onehot0(g1) || !$onehot0(g2)) begin
                errors++;
                $display("FAIL onehot c=%0d: got g0=%b g1=%b g2=%b expected one-hot or zero", c, g0, g1, g2);
            end
        end
    endtask

    initial begin
        m[0].n = 2;
        m[0].mh = 0;
        m[1].n = 2;
        m[1].mh = 4;
        m[2].n = 3;
        m[2].mh = 2;
        for (int i = 0; i < 3; i++) mreset(i);
        test_reset();
        test_request_release();
        test_switch();
        test_hold_limit();
        test_no_contention();
        test_three();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
